// File: rtl/fir_filter_param.sv
// Purpose: parameterised pipelined FIR filter with shadow/active coefficient banks.
// Latency: 3 + ceil(log2(NTAPS)) cycles from sample accept to out_valid (7 at defaults).
// Backpressure: the whole pipeline freezes while out_valid && !out_ready; in_ready = !out_valid || out_ready.
//
// Ports:
//   CLK, RST                               sampling clock, asynchronous active-low reset
//   in_valid / in_ready / in_data          signed sample input handshake
//   out_valid / out_ready / out_data       signed filtered sample output handshake
//   out_sat                                out_data was clipped (qualified by out_valid)
//   coef_we / coef_addr / coef_data        write one tap of the shadow coefficient bank
//   coef_commit                            copy the shadow bank into the active bank
module fir_filter_param #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int NTAPS  = 9,
  parameter int FRAC   = 14
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_sat,
  input  logic                     coef_we,
  input  logic [4:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     coef_commit
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int D      = $clog2(NTAPS);
  localparam int ACC_W  = PROD_W + D;

  // Number of operands present at a given adder-tree level (level 0 = products).
  function automatic int nodes_at(input int lvl);
    int n;
    n = NTAPS;
    for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // Unity gain in the coefficient format.
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1) << FRAC;

  // Half-LSB of the output grid, added before the arithmetic shift (round half-up).
  localparam logic signed [ACC_W:0] RND_K =
    (FRAC > 0) ? ((ACC_W + 1)'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;

  // Representable output range expressed at rounded-sum width.
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};
  localparam logic signed [DATA_W-1:0] SAT_HI = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_LO = {1'b1, {(DATA_W - 1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic out_valid_q;
  logic en_w;
  logic accept_w;

  assign en_w     = !out_valid_q || out_ready;
  assign in_ready = en_w;
  assign accept_w = in_valid && en_w;

  // ---------------------------------------------------------------------------
  // Coefficient banks
  // ---------------------------------------------------------------------------
  logic signed [COEF_W-1:0] shadow_q [NTAPS];
  logic signed [COEF_W-1:0] shadow_d [NTAPS];
  logic signed [COEF_W-1:0] active_q [NTAPS];

  // The shadow next-state already contains this cycle's write, so a commit in
  // the same cycle as a write picks the written value up.
  always_comb begin
    for (int k = 0; k < NTAPS; k++) begin
      shadow_d[k] = shadow_q[k];
      if (coef_we && (coef_addr == 5'(k))) shadow_d[k] = coef_data;
    end
  end

  // Coefficient banks ignore EN: writes and commits land in any cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= (k == 0) ? COEF_ONE : '0;
        active_q[k] <= (k == 0) ? COEF_ONE : '0;
      end
    end else begin
      shadow_q <= shadow_d;
      if (coef_commit) active_q <= shadow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Delay line: shifts only on an accepted sample; an idle enabled cycle just
  // clears the stage valid (bubble) and leaves the taps where they are.
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] tap_q [NTAPS];
  logic                     tap_vld_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tap_vld_q <= 1'b0;
      for (int k = 0; k < NTAPS; k++) tap_q[k] <= '0;
    end else if (en_w) begin
      tap_vld_q <= accept_w;
      if (accept_w) begin
        tap_q[0] <= in_data;
        for (int k = 1; k < NTAPS; k++) tap_q[k] <= tap_q[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Multiply stage: full-width signed products. Operands are sign-extended to
  // the product width, so the low PROD_W bits are the exact signed product.
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0] prod_d [NTAPS];
  logic signed [PROD_W-1:0] prod_q [NTAPS];
  logic                     prod_vld_q;

  always_comb begin
    for (int k = 0; k < NTAPS; k++) begin
      prod_d[k] = {{COEF_W{tap_q[k][DATA_W-1]}}, tap_q[k]} *
                  {{DATA_W{active_q[k][COEF_W-1]}}, active_q[k]};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prod_vld_q <= 1'b0;
      for (int k = 0; k < NTAPS; k++) prod_q[k] <= '0;
    end else if (en_w) begin
      prod_vld_q <= tap_vld_q;
      prod_q     <= prod_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered binary adder tree, one bit of growth per level. An unpaired
  // operand at the end of a level is sign-extended and registered unchanged.
  // ---------------------------------------------------------------------------
  for (genvar l = 1; l <= D; l++) begin : g_lvl
    localparam int NI = nodes_at(l - 1);
    localparam int NO = nodes_at(l);
    localparam int WI = PROD_W + l - 1;
    localparam int WO = PROD_W + l;

    logic signed [WI-1:0] opnd_w [NI];
    logic signed [WO-1:0] sum_d  [NO];
    logic signed [WO-1:0] sum_q  [NO];
    logic                 vld_in_w;
    logic                 vld_q;

    if (l == 1) begin : g_src
      assign vld_in_w = prod_vld_q;
      for (genvar i = 0; i < NI; i++) begin : g_op
        assign opnd_w[i] = prod_q[i];
      end
    end else begin : g_src
      assign vld_in_w = g_lvl[l-1].vld_q;
      for (genvar i = 0; i < NI; i++) begin : g_op
        assign opnd_w[i] = g_lvl[l-1].sum_q[i];
      end
    end

    for (genvar i = 0; i < NO; i++) begin : g_node
      if (2 * i + 1 < NI) begin : g_pair
        assign sum_d[i] = {opnd_w[2*i][WI-1], opnd_w[2*i]} +
                          {opnd_w[2*i+1][WI-1], opnd_w[2*i+1]};
      end else begin : g_pass
        assign sum_d[i] = {opnd_w[2*i][WI-1], opnd_w[2*i]};
      end
    end

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        vld_q <= 1'b0;
        for (int i = 0; i < NO; i++) sum_q[i] <= '0;
      end else if (en_w) begin
        vld_q <= vld_in_w;
        sum_q <= sum_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round half-up, arithmetic shift by FRAC, saturate to DATA_W.
  // One extra bit of headroom keeps the rounding add from wrapping.
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0]  sum_fin_w;
  logic                     fin_vld_w;
  logic signed [ACC_W:0]    rnd_w;
  logic signed [ACC_W:0]    shr_w;
  logic signed [DATA_W-1:0] out_data_d;
  logic                     out_sat_d;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     out_sat_q;

  assign sum_fin_w = g_lvl[D].sum_q[0];
  assign fin_vld_w = g_lvl[D].vld_q;
  assign rnd_w     = {sum_fin_w[ACC_W-1], sum_fin_w} + RND_K;
  assign shr_w     = rnd_w >>> FRAC;

  always_comb begin
    out_data_d = shr_w[DATA_W-1:0];
    out_sat_d  = 1'b0;
    if (shr_w > MAXV) begin
      out_data_d = SAT_HI;
      out_sat_d  = 1'b1;
    end else if (shr_w < MINV) begin
      out_data_d = SAT_LO;
      out_sat_d  = 1'b1;
    end
  end

  // Output register only moves with EN, so a stalled result stays put.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (en_w) begin
      out_valid_q <= fin_vld_w;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_filter_param.sv
module tb_fir_filter_param;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [15:0] coef_data;
  logic        coef_commit;

  fir_filter_param dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_commit(coef_commit)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks;
  int errors;
  int cyc;

  // Observed output stream and the independent reference stream.
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];
  int          got_cyc[$];
  int          acc_cyc[$];
  int          hist[$];
  int          sh_m[9];
  int          act_m[9];

  logic        obs_vld, obs_rdy, obs_acc, obs_sat;
  logic [15:0] obs_dat;

  logic [15:0] H [9];
  logic [15:0] ALL1 [9];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] got(input int i);
    if (i < got_q.size()) return got_q[i];
    return 'x;
  endfunction

  function automatic int lat(input int i);
    if (i < got_cyc.size() && i < acc_cyc.size()) return got_cyc[i] - acc_cyc[i];
    return -1;
  endfunction

  function automatic logic [15:0] tbl(input int i);
    logic [31:0] t;
    t = (i * 32'h1357) ^ 32'h0000A5A5;
    return t[15:0];
  endfunction

  // Direct-form FIR reference: newest accepted sample in hist[0].
  function automatic logic [16:0] model(input int c[9]);
    longint s;
    s = 0;
    for (int k = 0; k < 9; k++)
      if (k < hist.size()) s += longint'(hist[k]) * longint'(c[k]);
    s = (s + 8192) >>> 14;
    if (s > 32767)  return {1'b1, 16'h7FFF};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(s)};
  endfunction

  task automatic model_clear();
    got_q.delete(); exp_q.delete(); got_cyc.delete(); acc_cyc.delete(); hist.delete();
    for (int k = 0; k < 9; k++) begin
      sh_m[k]  = (k == 0) ? 16384 : 0;
      act_m[k] = (k == 0) ? 16384 : 0;
    end
  endtask

  // One clock cycle: drive, sample away from the edge, update the reference.
  task automatic feed(input logic v, input logic [15:0] d, input logic ordy);
    int nxt[9];
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    obs_vld = out_valid;
    obs_rdy = in_ready;
    obs_dat = out_data;
    obs_sat = out_sat;
    obs_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      got_q.push_back({out_sat, out_data});
      got_cyc.push_back(cyc);
    end
    if (coef_we && coef_addr < 5'd9) sh_m[int'(coef_addr)] = int'($signed(coef_data));
    for (int k = 0; k < 9; k++) nxt[k] = coef_commit ? sh_m[k] : act_m[k];
    if (obs_acc) begin
      hist.push_front(int'($signed(d)));
      exp_q.push_back(model(nxt));
      acc_cyc.push_back(cyc);
    end
    act_m = nxt;
    @(posedge CLK);
    #1;
    cyc++;
    in_valid    = 1'b0;
    coef_we     = 1'b0;
    coef_commit = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b0; in_valid = 1'b0; out_ready = 1'b1; coef_we = 1'b0; coef_commit = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    cyc++;
    model_clear();
  endtask

  task automatic load_coefs(input logic [15:0] c [9]);
    for (int k = 0; k < 9; k++) begin
      coef_we = 1'b1; coef_addr = 5'(k); coef_data = c[k];
      feed(1'b0, 16'h0000, 1'b1);
    end
    coef_commit = 1'b1;
    feed(1'b0, 16'h0000, 1'b1);
  endtask

  task automatic cmp_model(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got(i), exp_q[i]);
  endtask

  initial begin
    int          idx;
    logic        ordy;
    logic [16:0] held;

    H[0] = 16'h04F6; H[1] = 16'h0AE4; H[2] = 16'h1089; H[3] = 16'h1496; H[4] = 16'h160F;
    H[5] = 16'h1496; H[6] = 16'h1089; H[7] = 16'h0AE4; H[8] = 16'h04F6;
    for (int k = 0; k < 9; k++) ALL1[k] = 16'h4000;

    checks = 0; errors = 0; cyc = 0;
    RST = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 1);
    RST = 1'b1;

    // Identity coefficients straight out of reset, latency 7
    feed(1'b1, 16'h1234, 1'b1);
    feed(1'b1, 16'hC000, 1'b1);
    feed(1'b1, 16'h7FFF, 1'b1);
    repeat (10) feed(1'b0, 16'h0000, 1'b1);
    check("id_count", got_q.size(), 3);
    check("id_0", got(0), {1'b0, 16'h1234});
    check("id_1", got(1), {1'b0, 16'hC000});
    check("id_2", got(2), {1'b0, 16'h7FFF});
    for (int i = 0; i < 3; i++) check($sformatf("id_lat[%0d]", i), lat(i), 7);

    // Impulse response; out-of-range address write must be ignored
    do_reset();
    for (int k = 0; k < 9; k++) begin
      coef_we = 1'b1; coef_addr = 5'(k); coef_data = H[k];
      feed(1'b0, 16'h0000, 1'b1);
    end
    coef_we = 1'b1; coef_addr = 5'd16; coef_data = 16'h7FFF;
    feed(1'b0, 16'h0000, 1'b1);
    coef_commit = 1'b1;
    feed(1'b0, 16'h0000, 1'b1);
    feed(1'b1, 16'h4000, 1'b1);
    repeat (8) feed(1'b1, 16'h0000, 1'b1);
    repeat (12) feed(1'b0, 16'h0000, 1'b1);
    check("imp_count", got_q.size(), 9);
    for (int k = 0; k < 9; k++) check($sformatf("imp[%0d]", k), got(k), {1'b0, H[k]});

    // Positive saturation
    do_reset();
    load_coefs(ALL1);
    repeat (12) feed(1'b1, 16'h7FFF, 1'b1);
    repeat (12) feed(1'b0, 16'h0000, 1'b1);
    check("satp_count", got_q.size(), 12);
    check("satp[0]", got(0), {1'b0, 16'h7FFF});
    for (int i = 1; i < 12; i++) check($sformatf("satp[%0d]", i), got(i), {1'b1, 16'h7FFF});

    // Negative saturation
    do_reset();
    load_coefs(ALL1);
    repeat (12) feed(1'b1, 16'h8000, 1'b1);
    repeat (12) feed(1'b0, 16'h0000, 1'b1);
    check("satn_count", got_q.size(), 12);
    check("satn[0]", got(0), {1'b0, 16'h8000});
    for (int i = 1; i < 12; i++) check($sformatf("satn[%0d]", i), got(i), {1'b1, 16'h8000});

    // Backpressure: 5-cycle downstream stall mid-stream
    do_reset();
    load_coefs(H);
    idx = 0;
    held = '0;
    for (int c = 0; c < 40; c++) begin
      ordy = !(c >= 12 && c < 17);
      feed(idx < 24, tbl(idx), ordy);
      if (c >= 12 && c < 17) begin
        check("bp_in_ready", obs_rdy, 0);
        check("bp_out_valid", obs_vld, 1);
        if (c == 12) held = {obs_sat, obs_dat};
        else check("bp_hold", {obs_sat, obs_dat}, held);
      end
      if (obs_acc) idx++;
    end
    repeat (12) feed(1'b0, 16'h0000, 1'b1);
    check("bp_accepted", idx, 24);
    cmp_model("bp");

    // Shadow writes mid-stream, commit later
    do_reset();
    for (int c = 0; c < 34; c++) begin
      if (c >= 3 && c < 12) begin
        coef_we = 1'b1; coef_addr = 5'(c - 3); coef_data = H[c-3];
      end
      if (c == 14) coef_commit = 1'b1;
      feed(c < 20, tbl(c + 30), 1'b1);
    end
    cmp_model("cm");
    for (int j = 0; j < 14; j++) check($sformatf("cm_old[%0d]", j), got(j), {1'b0, tbl(j + 30)});

    // Reset mid-stream with 4 samples in flight and output stalled
    do_reset();
    load_coefs(H);
    for (int c = 0; c < 12; c++) feed(c < 4, tbl(c + 60), 1'b0);
    check("mr_pre_valid", out_valid, 1);
    RST = 1'b0;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_data", out_data, 0);
    check("mr_sat", out_sat, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    cyc++;
    model_clear();
    feed(1'b1, 16'h2468, 1'b1);
    repeat (10) feed(1'b0, 16'h0000, 1'b1);
    check("mr_count", got_q.size(), 1);
    check("mr_out", got(0), {1'b0, 16'h2468});
    check("mr_lat", lat(0), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
